// File: rtl/shutdown_seq_pkg.sv
// Shared definitions for the shutdown sequencer: FSM state encoding and small helpers.
package shutdown_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_PULSE    = 2'd2,
    ST_ENABLED  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// One shutdown source: multi-flop synchroniser followed by an asymmetric debouncer
// (asserts immediately, releases only after DEBOUNCE_CYCLES consecutive clear cycles).
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sd_async,
  output logic sd_clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       clear_cnt;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Flops reset to 1 so the source reads as shut down until proven clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sd_async};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clear_cnt <= '0;
      sd_clean  <= 1'b1;
    end else if (sync_out) begin
      clear_cnt <= '0;
      sd_clean  <= 1'b1;
    end else begin
      if (clear_cnt >= CNT_LAST) begin
        sd_clean <= 1'b0;
      end
      if (clear_cnt != CNT_MAX) begin
        clear_cnt <= clear_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shutdown_sequencer.sv
// Shutdown sequencer: debounced shutdown sources force GPIO to safe defaults; re-enable via ARMING + PULSE.
// Define SHUTDOWN_LATCH_EN to require a latch_clear acknowledge before re-arming after a fault.
module shutdown_sequencer
  import shutdown_seq_pkg::*;
#(
  parameter int NUM_IN          = 3,
  parameter int NUM_IOS         = 49,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RESTART_DELAY   = 100,
  parameter int PULSE_CYCLES    = 100
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IN-1:0]  shutdown,
  input  logic [NUM_IOS-1:0] gpio_in,
  input  logic [NUM_IOS-1:0] gpio_out_default,
  output logic [NUM_IOS-1:0] gpio_out,
  output logic               periph_reset,
  input  logic               latch_clear,
  output logic [NUM_IN-1:0]  fault_src,
  output logic [1:0]         state
);

  localparam int DLY_MAX = max_int(RESTART_DELAY, PULSE_CYCLES);
  localparam int CNT_W   = $clog2(DLY_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DLY_MAX);
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(RESTART_DELAY - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'((PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0);

  logic [NUM_IN-1:0] sd_clean;
  logic              any_sd;
  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  dly_cnt;
  logic              latch_accept;
  logic              rearm_ok;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_src
    sync_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .sd_async(shutdown[i]),
      .sd_clean(sd_clean[i])
    );
  end

  assign any_sd = |sd_clean;

`ifdef SHUTDOWN_LATCH_EN
  logic fault_latched;

  // Acknowledge only counts once every source has released; an early one is simply dropped.
  assign latch_accept = latch_clear && !any_sd && (state_q == ST_DISABLED);
  assign rearm_ok     = !fault_latched || latch_accept;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_latched <= 1'b0;
    end else if (any_sd && (state_q != ST_DISABLED)) begin
      fault_latched <= 1'b1;
    end else if (latch_accept) begin
      fault_latched <= 1'b0;
    end
  end
`else
  logic unused_latch_clear;

  assign unused_latch_clear = latch_clear;
  assign latch_accept       = 1'b0;
  assign rearm_ok           = 1'b1;
`endif

  // A live shutdown overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (any_sd) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: if (rearm_ok) state_d = ST_ARMING;
        ST_ARMING:   if (dly_cnt == ARM_LAST)
                       state_d = (PULSE_CYCLES == 0) ? ST_ENABLED : ST_PULSE;
        ST_PULSE:    if (dly_cnt == PULSE_LAST) state_d = ST_ENABLED;
        ST_ENABLED:  state_d = ST_ENABLED;
        default:     state_d = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_DISABLED;
    end else begin
      state_q <= state_d;
    end
  end

  // Delay counter restarts on every state entry, so an aborted sequence reruns in full.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dly_cnt <= '0;
    end else if (state_d != state_q) begin
      dly_cnt <= '0;
    end else if (dly_cnt != CNT_MAX) begin
      dly_cnt <= dly_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gpio_out  <= '0;
      fault_src <= '0;
    end else begin
      gpio_out <= ((state_q == ST_ENABLED) && !any_sd) ? gpio_in : gpio_out_default;
      if (any_sd && (state_q != ST_DISABLED)) begin
        fault_src <= sd_clean;
      end else if (latch_accept) begin
        fault_src <= '0;
      end
    end
  end

  assign periph_reset = (state_q == ST_PULSE);
  assign state        = state_q;

endmodule

// File: tb/tb_shutdown_sequencer.sv
// Scoreboard bench for shutdown_sequencer: stimulus queues expected output changes, monitor compares them.
// Build with SHUTDOWN_LATCH_EN defined to exercise the latched-fault variant.
module tb_shutdown_sequencer;

  localparam int NUM_IN  = 3;
  localparam int NUM_IOS = 8;

  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_ARM = 2'd1;
  localparam logic [1:0] S_PUL = 2'd2;
  localparam logic [1:0] S_EN  = 2'd3;

`ifdef SHUTDOWN_LATCH_EN
  localparam bit LATCH_BUILD = 1'b1;
`else
  localparam bit LATCH_BUILD = 1'b0;
`endif

  typedef struct {
    int         at_edge;
    logic [1:0] st;
    logic       pr;
    logic [7:0] gout;
    logic [2:0] fsrc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_IN-1:0]  shutdown;
  logic [NUM_IOS-1:0] gpio_in;
  logic [NUM_IOS-1:0] gpio_out_default;
  logic [NUM_IOS-1:0] gpio_out;
  logic               periph_reset;
  logic               latch_clear;
  logic [NUM_IN-1:0]  fault_src;
  logic [1:0]         state;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_no  = 0;
  logic        mon_en   = 1'b0;
  logic        obs_primed;
  logic [13:0] obs_cur;
  logic [13:0] obs_last;
  exp_t        obs_exp;

  shutdown_sequencer #(
    .NUM_IN         (NUM_IN),
    .NUM_IOS        (NUM_IOS),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RESTART_DELAY  (8),
    .PULSE_CYCLES   (3)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .shutdown        (shutdown),
    .gpio_in         (gpio_in),
    .gpio_out_default(gpio_out_default),
    .gpio_out        (gpio_out),
    .periph_reset    (periph_reset),
    .latch_clear     (latch_clear),
    .fault_src       (fault_src),
    .state           (state)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (edge %0d)", name, actual, expected, edge_no);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sd, input logic lc);
    shutdown    = sd;
    latch_clear = lc;
  endtask

  task automatic waitEdge(input int n);
    while (edge_no < n) @(negedge clk);
  endtask

  function automatic exp_t ev(input int e, input logic [1:0] st, input logic pr,
                              input logic [7:0] g, input logic [2:0] f);
    exp_t r;
    r.at_edge = e;
    r.st      = st;
    r.pr      = pr;
    r.gout    = g;
    r.fsrc    = f;
    return r;
  endfunction

  // fault_src after an accepted acknowledge: cleared only in the latched build.
  function automatic logic [2:0] fac(input logic [2:0] f);
    return LATCH_BUILD ? 3'b000 : f;
  endfunction

  // ARMING at edge a, PULSE 8 edges later for 3 edges, ENABLED, live data one edge after that.
  task automatic pushRearm(input int a, input logic [7:0] dflt, input logic [2:0] f, input logic [7:0] g);
    exp_q.push_back(ev(a,      S_ARM, 1'b0, dflt, f));
    exp_q.push_back(ev(a + 8,  S_PUL, 1'b1, dflt, f));
    exp_q.push_back(ev(a + 11, S_EN,  1'b0, dflt, f));
    exp_q.push_back(ev(a + 12, S_EN,  1'b0, g,    f));
  endtask

  // Monitor: every observed change of the output tuple consumes one expected record.
  always @(negedge clk) begin
    obs_cur = {state, periph_reset, gpio_out, fault_src};
    if (!mon_en) begin
      obs_primed = 1'b0;
    end else if (!obs_primed) begin
      obs_last   = obs_cur;
      obs_primed = 1'b1;
    end else if (obs_cur !== obs_last) begin
      obs_last = obs_cur;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_change actual=0x%0h expected=no change (edge %0d)", obs_cur, edge_no);
      end else begin
        obs_exp = exp_q.pop_front();
        checkOutput("event_edge",   32'(edge_no),      32'(obs_exp.at_edge));
        checkOutput("state",        32'(state),        32'(obs_exp.st));
        checkOutput("periph_reset", 32'(periph_reset), 32'(obs_exp.pr));
        checkOutput("gpio_out",     32'(gpio_out),     32'(obs_exp.gout));
        checkOutput("fault_src",    32'(fault_src),    32'(obs_exp.fsrc));
      end
    end
  end

  initial begin : stimulus
    int e;
    reset_n          = 1'b0;
    shutdown         = '0;
    gpio_in          = 8'hA5;
    gpio_out_default = 8'h00;
    latch_clear      = 1'b0;
    waitEdge(3);

    // Power-up
    checkOutput("reset_state",        32'(state),        32'(S_DIS));
    checkOutput("reset_periph_reset", 32'(periph_reset), 32'd0);
    checkOutput("reset_gpio_out",     32'(gpio_out),     32'd0);
    checkOutput("reset_fault_src",    32'(fault_src),    32'd0);
    mon_en = 1'b1;
    e = edge_no;
    pushRearm(e + 7, 8'h00, 3'b000, 8'hA5);
    exp_q.push_back(ev(e + 23, S_EN, 1'b0, 8'h3C, 3'b000));
    exp_q.push_back(ev(e + 25, S_EN, 1'b0, 8'hA5, 3'b000));
    reset_n = 1'b1;
    waitEdge(e + 22);
    gpio_in = 8'h3C;
    waitEdge(e + 24);
    gpio_in = 8'hA5;
    waitEdge(e + 28);

    // Single-cycle shutdown[1] in ENABLED
    e = edge_no;
    exp_q.push_back(ev(e + 4, S_DIS, 1'b0, 8'h00, 3'b010));
    pushRearm(e + 8, 8'h00, fac(3'b010), 8'hA5);
    applyStimulus(3'b010, 1'b0);
    waitEdge(e + 1);  applyStimulus(3'b000, 1'b0);
    waitEdge(e + 7);  applyStimulus(3'b000, 1'b1);
    waitEdge(e + 8);  applyStimulus(3'b000, 1'b0);
    waitEdge(e + 24);

    // Glitching shutdown[0]: clear runs of 3 never release
    e = edge_no;
    exp_q.push_back(ev(e + 4, S_DIS, 1'b0, 8'h00, 3'b001));
    pushRearm(e + 28, 8'h00, fac(3'b001), 8'hA5);
    for (int r = 0; r < 6; r++) begin
      waitEdge(e + 4 * r);     applyStimulus(3'b001, 1'b0);
      waitEdge(e + 4 * r + 1); applyStimulus(3'b000, 1'b0);
    end
    waitEdge(e + 27);
    checkOutput("glitch_hold_state", 32'(state), 32'(S_DIS));
    applyStimulus(3'b000, 1'b1);
    waitEdge(e + 28); applyStimulus(3'b000, 1'b0);
    waitEdge(e + 44);

    // shutdown[2] reaches the FSM in the 2nd PULSE cycle; nonzero safe default
    e = edge_no;
    gpio_out_default = 8'h5A;
    exp_q.push_back(ev(e + 4,  S_DIS, 1'b0, 8'h5A, 3'b100));
    exp_q.push_back(ev(e + 8,  S_ARM, 1'b0, 8'h5A, fac(3'b100)));
    exp_q.push_back(ev(e + 16, S_PUL, 1'b1, 8'h5A, fac(3'b100)));
    exp_q.push_back(ev(e + 18, S_DIS, 1'b0, 8'h5A, 3'b100));
    pushRearm(e + 23, 8'h5A, fac(3'b100), 8'hA5);
    applyStimulus(3'b100, 1'b0);
    waitEdge(e + 1);  applyStimulus(3'b000, 1'b0);
    waitEdge(e + 7);  applyStimulus(3'b000, 1'b1);
    waitEdge(e + 8);  applyStimulus(3'b000, 1'b0);
    waitEdge(e + 14); applyStimulus(3'b100, 1'b0);
    waitEdge(e + 16); applyStimulus(3'b000, 1'b0);
    waitEdge(e + 22); applyStimulus(3'b000, 1'b1);
    waitEdge(e + 23); applyStimulus(3'b000, 1'b0);
    waitEdge(e + 38);
    gpio_out_default = 8'h00;
    waitEdge(e + 40);

    // Fault acknowledge behaviour
    e = edge_no;
    exp_q.push_back(ev(e + 4, S_DIS, 1'b0, 8'h00, 3'b010));
`ifdef SHUTDOWN_LATCH_EN
    pushRearm(e + 131, 8'h00, 3'b000, 8'hA5);
    applyStimulus(3'b010, 1'b0);
    waitEdge(e + 1);   applyStimulus(3'b000, 1'b0);
    waitEdge(e + 110);
    checkOutput("latch_hold_state", 32'(state), 32'(S_DIS));
    applyStimulus(3'b001, 1'b0);
    waitEdge(e + 115); applyStimulus(3'b001, 1'b1);
    waitEdge(e + 116); applyStimulus(3'b000, 1'b0);
    waitEdge(e + 130);
    checkOutput("latch_ignored_state", 32'(state), 32'(S_DIS));
    applyStimulus(3'b000, 1'b1);
    waitEdge(e + 131); applyStimulus(3'b000, 1'b0);
    waitEdge(e + 146);
`else
    pushRearm(e + 8, 8'h00, 3'b010, 8'hA5);
    applyStimulus(3'b010, 1'b0);
    waitEdge(e + 1);   applyStimulus(3'b000, 1'b0);
    waitEdge(e + 24);
`endif

    // Reset mid-ENABLED reproduces the power-up timing
    e = edge_no;
    exp_q.push_back(ev(e + 1, S_DIS, 1'b0, 8'h00, 3'b000));
    pushRearm(e + 10, 8'h00, 3'b000, 8'hA5);
    reset_n = 1'b0;
    waitEdge(e + 3);
    reset_n = 1'b1;
    waitEdge(e + 26);

    checkOutput("pending_events", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
